// File: rtl/hls_macc_motion_pkg.sv
// Shared types and constants for the hls_macc_motion_n block: FSM state
// encoding, default key constant and the index-width helper.
package hls_macc_motion_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [31:0] KEY_MAGIC_DEFAULT = 32'hCAAA_AA82;

  // Bits needed to index 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hls_macc_motion_lane.sv
// One correlation lane: a W-bit wrapping accumulator fed by a signed
// product whose upper half is discarded.
module hls_macc_motion_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc
);

  logic [W-1:0] prod_lo;

  // The low W bits of the full 2W signed product do not depend on the upper
  // half, so a W-wide multiply yields exactly the truncated result.
  assign prod_lo = W'($signed(a) * $signed(b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      acc <= acc + prod_lo;
    end
  end

endmodule

// File: rtl/hls_macc_motion_n.sv
// NOUT-lag circular cross-correlation over NTAP signed pairs behind an
// ap_start/ap_done handshake. Define HLS_MACC_MOTION_KEYLOCK_EN to add the
// working_key port that masks every result.
module hls_macc_motion_n
  import hls_macc_motion_pkg::*;
#(
  parameter int                NTAP      = 5,
  parameter int                NOUT      = 3,
  parameter int                W         = 32,
  parameter int                KEY_W     = 32,
  parameter logic [KEY_W-1:0]  KEY_MAGIC = KEY_W'(KEY_MAGIC_DEFAULT)
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  input  logic [NTAP*W-1:0]   in_a,
  input  logic [NTAP*W-1:0]   in_b,
`ifdef HLS_MACC_MOTION_KEYLOCK_EN
  input  logic [KEY_W-1:0]    working_key,
`endif
  output logic [NOUT*W-1:0]   out_data,
  output logic [NOUT-1:0]     out_vld
);

  localparam int IDX_W = clog2(NTAP);

  if (NTAP < 2 || NTAP > 64) begin : g_bad_ntap
    $error("hls_macc_motion_n: NTAP must be in 2..64");
  end
  if (NOUT < 1 || NOUT > NTAP) begin : g_bad_nout
    $error("hls_macc_motion_n: NOUT must be in 1..NTAP");
  end
  if (KEY_W < W || $bits(KEY_MAGIC) != KEY_W) begin : g_bad_key
    $error("hls_macc_motion_n: KEY_W must be at least W");
  end

  state_e             state_q;
  state_e             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               load;
  logic               last;
  logic [W-1:0]       a_q [NTAP];
  logic [W-1:0]       b_q [NTAP];
  logic [NOUT*W-1:0]  acc_flat;
  logic [NOUT*W-1:0]  res_q;
  logic [NOUT*W-1:0]  raw;

  assign load = (state_q == S_IDLE) && ap_start;
  assign last = (idx_q == IDX_W'(NTAP - 1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        idx_q <= '0;
      end else if (state_q == S_RUN) begin
        idx_q <= last ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ap_start) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the sample store is deliberately left out of reset; it is always
  // written on job start before any lane reads it, so reset would only add
  // fan-out to a wide register bank.
  always_ff @(posedge ap_clk) begin
    if (load) begin
      for (int i = 0; i < NTAP; i++) begin
        a_q[i] <= in_a[i*W +: W];
        b_q[i] <= in_b[i*W +: W];
      end
    end
  end

  for (genvar k = 0; k < NOUT; k++) begin : g_lane
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] b_idx;

    // (idx + k) mod NTAP: both terms are below NTAP, so one conditional
    // subtract is enough.
    assign sum   = {1'b0, idx_q} + (IDX_W+1)'(k);
    assign b_idx = (sum >= (IDX_W+1)'(NTAP)) ? IDX_W'(sum - (IDX_W+1)'(NTAP))
                                             : IDX_W'(sum);

    hls_macc_motion_lane #(
      .W (W)
    ) u_lane (
      .clk (ap_clk),
      .rst (ap_rst),
      .clr (load),
      .en  (state_q == S_RUN),
      .a   (a_q[idx_q]),
      .b   (b_q[b_idx]),
      .acc (acc_flat[k*W +: W])
    );
  end

  // The accumulators hold the final sums during DONE; res_q keeps them once
  // the next job clears the lanes, so out_data is stable until the next DONE.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      res_q <= '0;
    end else if (state_q == S_DONE) begin
      res_q <= acc_flat;
    end
  end

  assign raw = (state_q == S_DONE) ? acc_flat : res_q;

`ifdef HLS_MACC_MOTION_KEYLOCK_EN
  logic [W-1:0] mask;
  assign mask     = working_key[W-1:0] ^ KEY_MAGIC[W-1:0];
  assign out_data = raw ^ {NOUT{mask}};
`else
  assign out_data = raw;
`endif

  assign ap_idle  = (state_q == S_IDLE);
  assign ap_done  = (state_q == S_DONE);
  assign ap_ready = (state_q == S_DONE);
  assign out_vld  = {NOUT{state_q == S_DONE}};

endmodule
